clk_monitor: RTL

Synthesizable checker for a generated clock. It samples a slow, asynchronous square wave (MON_IN, e.g. a generated or divided clock) in the system CLK domain and measures each high and low segment in CLK cycles. It compares each measurement against an expected half period, flags deviations and stuck input, and asserts LOCKED after a run of good segments. It sits on the receiving end of any clock source whose half period is a known multiple of the system clock.

---
 rtl/clk_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clk_monitor.sv
// Clock monitor: measures high/low segments of an asynchronous square wave in
// system clock cycles, flags out-of-tolerance or stuck segments and reports lock.
module clk_monitor #(
    parameter int HALF_PERIOD = 10,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_in,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             period_valid,
    output logic [CNT_W-1:0] last_high,
    output logic [CNT_W-1:0] last_low
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LO_LEN  = (HALF_PERIOD > TOL) ? CNT_W'(HALF_PERIOD - TOL) : '0;
    localparam logic [CNT_W-1:0] HI_LEN  = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO_LEN = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    LOCK_G  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        WARM,
        SYNC,
        TRAIN,
        LOCK
    } state_t;

    state_t           state, state_n;
    logic             s1, s2, prev;
    logic [CNT_W-1:0] run_cnt, run_cnt_n;
    logic [1:0]       warm_cnt, warm_cnt_n;
    logic [GW-1:0]    good_cnt, good_cnt_n;
    logic             flagged, flagged_n;
    logic             err_evt, pv_n;
    logic [7:0]       err_cnt_n;
    logic [CNT_W-1:0] last_high_n, last_low_n;
    logic             transition, in_range, timeout;

    always_comb begin
        transition  = (s2 != prev);
        in_range    = (run_cnt >= LO_LEN) && (run_cnt <= HI_LEN);
        timeout     = (run_cnt == TMO_LEN);
        state_n     = state;
        warm_cnt_n  = warm_cnt;
        good_cnt_n  = good_cnt;
        flagged_n   = flagged;
        err_evt     = 1'b0;
        pv_n        = 1'b0;
        last_high_n = last_high;
        last_low_n  = last_low;

        if (transition)
            run_cnt_n = CNT_W'(1);
        else if (run_cnt == CNT_MAX)
            run_cnt_n = run_cnt;
        else
            run_cnt_n = run_cnt + CNT_W'(1);

        case (state)
            // Edges here are synchronizer fill, not real transitions.
            WARM: begin
                warm_cnt_n = warm_cnt + 2'd1;
                if (warm_cnt == 2'd2)
                    state_n = SYNC;
            end
            SYNC: begin
                if (transition) begin
                    state_n    = TRAIN;
                    good_cnt_n = '0;
                end
            end
            TRAIN, LOCK: begin
                if (transition) begin
                    pv_n      = 1'b1;
                    flagged_n = 1'b0;
                    if (prev)
                        last_high_n = run_cnt;
                    else
                        last_low_n = run_cnt;
                    if (in_range) begin
                        if (state == TRAIN) begin
                            good_cnt_n = good_cnt + GW'(1);
                            if (good_cnt_n == LOCK_G)
                                state_n = LOCK;
                        end
                    end else if (!flagged) begin
                        err_evt = 1'b1;
                    end
                end else if (timeout && !flagged) begin
                    // A stuck segment errors once here; its late edge must not error again.
                    err_evt   = 1'b1;
                    flagged_n = 1'b1;
                end
            end
            default: state_n = WARM;
        endcase

        if (err_evt) begin
            good_cnt_n = '0;
            state_n    = TRAIN;
        end

        err_cnt_n = (err_evt && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WARM;
            s1           <= 1'b0;
            s2           <= 1'b0;
            prev         <= 1'b0;
            run_cnt      <= '0;
            warm_cnt     <= '0;
            good_cnt     <= '0;
            flagged      <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_cnt      <= '0;
            period_valid <= 1'b0;
            last_high    <= '0;
            last_low     <= '0;
        end else begin
            state        <= state_n;
            s1           <= mon_in;
            s2           <= s1;
            prev         <= s2;
            run_cnt      <= run_cnt_n;
            warm_cnt     <= warm_cnt_n;
            good_cnt     <= good_cnt_n;
            flagged      <= flagged_n;
            locked       <= (state_n == LOCK);
            err          <= err_evt;
            err_cnt      <= err_cnt_n;
            period_valid <= pv_n;
            last_high    <= last_high_n;
            last_low     <= last_low_n;
        end
    end

endmodule
